conv_win3x3: RTL and testbench

Three-by-three window generator that sits directly downstream of the line-buffer controller in the convolution datapath. Each input beat is one pixel column: the two delayed rows from the line buffers plus the live pixel. The block shifts these columns into a sliding window and applies zero padding on the left and right borders. It also zero-masks the top and bottom rows on request. It emits one 3x3 window per input pixel to the convolution kernel over a valid/ready handshake.

---
 rtl/conv_pkg.sv | 7 +
 rtl/conv_win3x3_if.sv | 37 +++
 rtl/conv_win3x3.sv | 146 ++++++++++++++
 tb/tb_conv_win3x3.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared parameters for the convolution datapath.
package conv_pkg;

  // Bits per pixel throughout the convolution datapath.
  parameter int unsigned PIXEL_W = 8;

endpackage

// File: rtl/conv_win3x3_if.sv
// Column-in / window-out handshake bundle for conv_win3x3.
//   in_vld_i/in_rdy_o    : input column handshake
//   col_i                : [0] top (oldest), [1] middle, [2] bottom (live pixel)
//   sol_i/eol_i          : first / last column of the line
//   vpad_top_i/_bot_i    : zero the top / bottom pixel of this column
//   win_vld_o/win_rdy_i  : window handshake
//   win_o                : element r*3+c, r=0 top, c=0 left
//   win_sol_o/win_eol_o  : window is first / last of its line
//   err_o                : sticky protocol error
// The slave modport is the window generator; the master modport is its environment.
interface conv_win3x3_if #(
  parameter int unsigned PIXEL_W = conv_pkg::PIXEL_W
);
  logic                    in_vld_i;
  logic                    in_rdy_o;
  logic [2:0][PIXEL_W-1:0] col_i;
  logic                    sol_i;
  logic                    eol_i;
  logic                    vpad_top_i;
  logic                    vpad_bot_i;
  logic                    win_vld_o;
  logic                    win_rdy_i;
  logic [8:0][PIXEL_W-1:0] win_o;
  logic                    win_sol_o;
  logic                    win_eol_o;
  logic                    err_o;

  modport slave (
    input  in_vld_i, col_i, sol_i, eol_i, vpad_top_i, vpad_bot_i, win_rdy_i,
    output in_rdy_o, win_vld_o, win_o, win_sol_o, win_eol_o, err_o
  );

  modport master (
    output in_vld_i, col_i, sol_i, eol_i, vpad_top_i, vpad_bot_i, win_rdy_i,
    input  in_rdy_o, win_vld_o, win_o, win_sol_o, win_eol_o, err_o
  );
endinterface

// File: rtl/conv_win3x3.sv
// 3x3 sliding-window generator with horizontal zero padding and optional
// top/bottom row masking. One window per input column.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : conv_win3x3_if slave (column input, window output, err_o)
module conv_win3x3 #(
  parameter int unsigned PIXEL_W = conv_pkg::PIXEL_W
) (
  input logic          clk,
  input logic          rst,
  conv_win3x3_if.slave bus
);

  typedef logic [2:0][PIXEL_W-1:0] col_t;
  typedef logic [8:0][PIXEL_W-1:0] win_t;

  typedef enum logic [1:0] {StLineStart, StInLine, StFlush} state_e;

  state_e state_q, state_d;
  col_t   l_q, l_d, c_q, c_d;
  logic   first_q, first_d;
  logic   err_q, err_d;
  win_t   win_q, win_d;
  logic   win_vld_q, win_vld_d;
  logic   win_sol_q, win_sol_d;
  logic   win_eol_q, win_eol_d;

  col_t   m;
  col_t   right;
  logic   slot_free;
  logic   in_rdy;
  logic   accept;
  logic   emit;
  logic   emit_sol;
  logic   emit_eol;

  always_comb begin
    m = bus.col_i;
    if (bus.vpad_top_i) m[0] = '0;
    if (bus.vpad_bot_i) m[2] = '0;
  end

  assign slot_free = ~win_vld_q | bus.win_rdy_i;
  assign in_rdy    = slot_free & (state_q != StFlush);
  assign accept    = bus.in_vld_i & in_rdy;

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    c_d      = c_q;
    first_d  = first_q;
    err_d    = err_q;
    emit     = 1'b0;
    right    = m;
    emit_sol = first_q;
    emit_eol = 1'b0;

    unique case (state_q)
      StLineStart, StInLine: begin
        if (accept) begin
          if (bus.sol_i) begin
            // Left of the first pixel is padding; no window until the next column.
            l_d     = '0;
            c_d     = m;
            first_d = 1'b1;
            state_d = bus.eol_i ? StFlush : StInLine;
          end else if (state_q == StInLine) begin
            emit    = 1'b1;
            first_d = 1'b0;
            l_d     = c_q;
            c_d     = m;
            state_d = bus.eol_i ? StFlush : StInLine;
          end else begin
            // Mid-line beat with no line open: drop it.
            err_d = 1'b1;
          end
        end
      end
      StFlush: begin
        // Last window of the line, right of the last pixel is padding.
        if (slot_free) begin
          emit     = 1'b1;
          right    = '0;
          emit_eol = 1'b1;
          first_d  = 1'b0;
          state_d  = StLineStart;
        end
      end
      default: state_d = StLineStart;
    endcase
  end

  // Output register: reload whenever the slot is free, otherwise hold.
  always_comb begin
    win_vld_d = win_vld_q;
    win_d     = win_q;
    win_sol_d = win_sol_q;
    win_eol_d = win_eol_q;
    if (slot_free) win_vld_d = emit;
    if (emit) begin
      win_d[0]  = l_q[0];
      win_d[1]  = c_q[0];
      win_d[2]  = right[0];
      win_d[3]  = l_q[1];
      win_d[4]  = c_q[1];
      win_d[5]  = right[1];
      win_d[6]  = l_q[2];
      win_d[7]  = c_q[2];
      win_d[8]  = right[2];
      win_sol_d = emit_sol;
      win_eol_d = emit_eol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLineStart;
      l_q       <= '0;
      c_q       <= '0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
      win_sol_q <= 1'b0;
      win_eol_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      c_q       <= c_d;
      first_q   <= first_d;
      err_q     <= err_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      win_sol_q <= win_sol_d;
      win_eol_q <= win_eol_d;
    end
  end

  assign bus.in_rdy_o  = in_rdy;
  assign bus.win_vld_o = win_vld_q;
  assign bus.win_o     = win_q;
  assign bus.win_sol_o = win_sol_q;
  assign bus.win_eol_o = win_eol_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_conv_win3x3.sv
// Directed self-checking bench for conv_win3x3.
module tb_conv_win3x3;

  localparam int unsigned PW = 8;

  typedef logic [8:0][PW-1:0] win_t;
  typedef logic [PW*9+1:0]    rec_t; // {sol, eol, window}

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_win3x3_if #(.PIXEL_W(PW)) bus ();

  conv_win3x3 #(.PIXEL_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  rec_t got[$];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted windows, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && bus.win_vld_o && bus.win_rdy_i)
      got.push_back({bus.win_sol_o, bus.win_eol_o, bus.win_o});
  end

  function automatic rec_t mid_rec(input logic s, input logic e,
                                   input logic [PW-1:0] a, b, c);
    win_t w;
    w    = '0;
    w[3] = a;
    w[4] = b;
    w[5] = c;
    return {s, e, w};
  endfunction

  task automatic send_col(input logic [PW-1:0] top, mid, bot,
                          input logic s, e, vt, vb);
    bit done;
    done             = 1'b0;
    bus.in_vld_i     = 1'b1;
    bus.col_i[0]     = top;
    bus.col_i[1]     = mid;
    bus.col_i[2]     = bot;
    bus.sol_i        = s;
    bus.eol_i        = e;
    bus.vpad_top_i   = vt;
    bus.vpad_bot_i   = vb;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_rdy_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("accept_timeout", 128'd0, 128'd1);
    bus.in_vld_i   = 1'b0;
    bus.sol_i      = 1'b0;
    bus.eol_i      = 1'b0;
    bus.vpad_top_i = 1'b0;
    bus.vpad_bot_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_queue(input string tag, input rec_t exp[$]);
    check_eq({tag, "_count"}, 128'(got.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check_eq($sformatf("%s_win%0d", tag, i), 128'(got[i]), 128'(exp[i]));
    got.delete();
  endtask

  initial begin
    rec_t exp[$];
    win_t w;
    win_t held;

    bus.in_vld_i   = 1'b0;
    bus.col_i      = '0;
    bus.sol_i      = 1'b0;
    bus.eol_i      = 1'b0;
    bus.vpad_top_i = 1'b0;
    bus.vpad_bot_i = 1'b0;
    bus.win_rdy_i  = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_win_vld", 128'(bus.win_vld_o), 128'd0);
    check_eq("rst_err", 128'(bus.err_o), 128'd0);
    check_eq("rst_in_rdy", 128'(bus.in_rdy_o), 128'd1);
    check_eq("rst_win", 128'(bus.win_o), 128'd0);

    // Basic line 1,2,3,4 with FLUSH bubble
    send_col(0, 1, 0, 1, 0, 0, 0);
    send_col(0, 2, 0, 0, 0, 0, 0);
    send_col(0, 3, 0, 0, 0, 0, 0);
    send_col(0, 4, 0, 0, 1, 0, 0);
    check_eq("flush_in_rdy_low", 128'(bus.in_rdy_o), 128'd0);
    idle(1);
    check_eq("after_flush_in_rdy", 128'(bus.in_rdy_o), 128'd1);
    idle(3);
    exp = '{mid_rec(1, 0, 0, 1, 2), mid_rec(0, 0, 1, 2, 3),
            mid_rec(0, 0, 2, 3, 4), mid_rec(0, 1, 3, 4, 0)};
    check_queue("line4", exp);

    // Width-1 line with top padding
    send_col(5, 6, 7, 1, 1, 1, 0);
    idle(4);
    w    = '0;
    w[4] = 8'd6;
    w[7] = 8'd7;
    exp  = '{{1'b1, 1'b1, w}};
    check_queue("width1", exp);

    // Backpressure mid-line
    send_col(0, 1, 0, 1, 0, 0, 0);
    send_col(0, 2, 0, 0, 0, 0, 0);
    send_col(0, 3, 0, 0, 0, 0, 0);
    bus.win_rdy_i  = 1'b0;
    held           = bus.win_o;
    bus.in_vld_i   = 1'b1;
    bus.col_i      = '0;
    bus.col_i[1]   = 8'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("bp_hold%0d", i), 128'(bus.win_o), 128'(held));
      check_eq($sformatf("bp_in_rdy%0d", i), 128'(bus.in_rdy_o), 128'd0);
    end
    bus.win_rdy_i = 1'b1;
    send_col(0, 4, 0, 0, 0, 0, 0);
    send_col(0, 5, 0, 0, 0, 0, 0);
    send_col(0, 6, 0, 0, 1, 0, 0);
    idle(4);
    exp = '{mid_rec(1, 0, 0, 1, 2), mid_rec(0, 0, 1, 2, 3),
            mid_rec(0, 0, 2, 3, 4), mid_rec(0, 0, 3, 4, 5),
            mid_rec(0, 0, 4, 5, 6), mid_rec(0, 1, 5, 6, 0)};
    check_queue("bp", exp);

    // Protocol error after reset
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    send_col(0, 9, 0, 0, 0, 0, 0);
    idle(2);
    check_eq("err_set", 128'(bus.err_o), 128'd1);
    check_eq("err_no_win", 128'(got.size()), 128'd0);
    send_col(0, 1, 0, 1, 0, 0, 0);
    send_col(0, 2, 0, 0, 1, 0, 0);
    idle(4);
    check_eq("err_sticky", 128'(bus.err_o), 128'd1);
    exp = '{mid_rec(1, 0, 0, 1, 2), mid_rec(0, 1, 1, 2, 0)};
    check_queue("after_err", exp);

    // Reset mid-line with a pending window
    bus.win_rdy_i = 1'b0;
    send_col(0, 9, 0, 1, 0, 0, 0);
    send_col(0, 8, 0, 0, 0, 0, 0);
    check_eq("pend_vld", 128'(bus.win_vld_o), 128'd1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_eq("midrst_vld", 128'(bus.win_vld_o), 128'd0);
    check_eq("midrst_err", 128'(bus.err_o), 128'd0);
    bus.win_rdy_i = 1'b1;
    idle(3);
    check_eq("midrst_no_win", 128'(got.size()), 128'd0);
    send_col(1, 7, 2, 1, 0, 0, 0);
    send_col(3, 8, 4, 0, 1, 0, 0);
    idle(4);
    w    = '0;
    w[1] = 8'd1; w[2] = 8'd3;
    w[4] = 8'd7; w[5] = 8'd8;
    w[7] = 8'd2; w[8] = 8'd4;
    exp  = '{{1'b1, 1'b0, w}};
    w    = '0;
    w[0] = 8'd1; w[1] = 8'd3;
    w[3] = 8'd7; w[4] = 8'd8;
    w[6] = 8'd2; w[7] = 8'd4;
    exp.push_back({1'b0, 1'b1, w});
    check_queue("post_rst", exp);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
